// File: rtl/gelato_inst_buffer.sv
// gelato_inst_buffer
// Per-warp instruction buffer sitting between the decoder and issue/dispatch.
// Each warp owns an independent DEPTH-entry FIFO; issue picks one non-empty,
// eligible warp per cycle in round-robin order.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   in_valid/in_warp/in_inst/in_ready   decoder enqueue handshake
//   issue_eligible  per-warp eligibility mask from the scheduler
//   out_valid/out_warp/out_inst/out_ready  issue handshake (head of selected FIFO)
//   flush_valid/flush_warp  discard every buffered instruction of one warp
//   warp_empty      bit w set when warp w's FIFO holds nothing
module gelato_inst_buffer #(
  parameter int  NUM_WARPS  = 4,
  parameter int  DEPTH      = 2,
  parameter type inst_t     = logic [33:0],
  parameter type warp_num_t = logic [2:0]
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  warp_num_t            in_warp,
  input  inst_t                in_inst,
  output logic                 in_ready,
  input  logic [NUM_WARPS-1:0] issue_eligible,
  output logic                 out_valid,
  output warp_num_t            out_warp,
  output inst_t                out_inst,
  input  logic                 out_ready,
  input  logic                 flush_valid,
  input  warp_num_t            flush_warp,
  output logic [NUM_WARPS-1:0] warp_empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NWW = $clog2(NUM_WARPS);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  inst_t          mem_q    [NUM_WARPS][DEPTH];
  logic [CW-1:0]  count_q  [NUM_WARPS];
  logic [CW-1:0]  count_d  [NUM_WARPS];
  logic [PW-1:0]  rd_ptr_q [NUM_WARPS];
  logic [PW-1:0]  rd_ptr_d [NUM_WARPS];
  logic [PW-1:0]  wr_ptr_q [NUM_WARPS];
  logic [PW-1:0]  wr_ptr_d [NUM_WARPS];
  logic [NWW-1:0] rr_last_q;
  logic [NWW-1:0] rr_last_d;

  logic                 in_warp_ok;
  logic [NWW-1:0]       in_idx;
  logic [NUM_WARPS-1:0] cand;
  logic                 sel_found;
  logic [NWW-1:0]       sel_idx;
  logic [NWW-1:0]       scan_w;
  logic                 hit;
  logic                 enq;
  logic                 deq;
  logic [NUM_WARPS-1:0] enq_vec;
  logic [NUM_WARPS-1:0] deq_vec;
  logic [NUM_WARPS-1:0] flush_vec;

  // Input acceptance: out-of-range warps are never ready; no dequeue bypass.
  always_comb begin
    in_warp_ok = (32'(in_warp) < 32'(NUM_WARPS));
    in_idx     = in_warp[NWW-1:0];
    if (in_warp_ok) begin
      in_ready = (count_q[in_idx] != FULL_CNT) && !(flush_valid && (flush_warp == in_warp));
    end else begin
      in_ready = 1'b0;
    end
  end

  // Candidate mask and flush decode per warp.
  always_comb begin
    cand      = '0;
    flush_vec = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      flush_vec[w] = flush_valid && (32'(flush_warp) == 32'(w));
      cand[w]      = (count_q[w] != '0) && issue_eligible[w] && !flush_vec[w];
    end
  end

  // Round-robin scan starting just after the last warp that issued.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan_w    = '0;
    hit       = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      scan_w    = NWW'((32'(rr_last_q) + 32'(i)) % 32'(NUM_WARPS));
      hit       = !sel_found && cand[scan_w];
      sel_idx   = hit ? scan_w : sel_idx;
      sel_found = sel_found | hit;
    end
  end

  // Issue-side outputs and handshake qualifiers.
  always_comb begin
    out_valid = sel_found;
    out_warp  = '0;
    out_inst  = '0;
    enq       = in_valid && in_ready;
    deq       = sel_found && out_ready;
    if (sel_found) begin
      out_warp[NWW-1:0] = sel_idx;
      out_inst          = mem_q[sel_idx][rd_ptr_q[sel_idx]];
    end else begin
      out_warp = '0;
      out_inst = '0;
    end
  end

  // Next-state for pointers, counts and the round-robin marker.
  always_comb begin
    rr_last_d = rr_last_q;
    enq_vec   = '0;
    deq_vec   = '0;
    if (deq) begin
      rr_last_d = sel_idx;
    end else begin
      rr_last_d = rr_last_q;
    end
    for (int w = 0; w < NUM_WARPS; w++) begin
      count_d[w]  = count_q[w];
      rd_ptr_d[w] = rd_ptr_q[w];
      wr_ptr_d[w] = wr_ptr_q[w];
      enq_vec[w]  = enq && (in_idx == NWW'(w));
      deq_vec[w]  = deq && (sel_idx == NWW'(w));
      if (flush_vec[w]) begin
        // Flush wins; enqueue/dequeue to this warp are already blocked.
        count_d[w]  = '0;
        rd_ptr_d[w] = '0;
        wr_ptr_d[w] = '0;
      end else begin
        if (enq_vec[w]) begin
          wr_ptr_d[w] = wr_ptr_q[w] + PW'(1);
        end else begin
          wr_ptr_d[w] = wr_ptr_q[w];
        end
        if (deq_vec[w]) begin
          rd_ptr_d[w] = rd_ptr_q[w] + PW'(1);
        end else begin
          rd_ptr_d[w] = rd_ptr_q[w];
        end
        case ({enq_vec[w], deq_vec[w]})
          2'b10:   count_d[w] = count_q[w] + CW'(1);
          2'b01:   count_d[w] = count_q[w] - CW'(1);
          default: count_d[w] = count_q[w];
        endcase
      end
    end
  end

  // State registers; rr_last resets to the top warp so warp 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= NWW'(NUM_WARPS - 1);
      for (int w = 0; w < NUM_WARPS; w++) begin
        count_q[w]  <= '0;
        rd_ptr_q[w] <= '0;
        wr_ptr_q[w] <= '0;
      end
    end else begin
      rr_last_q <= rr_last_d;
      for (int w = 0; w < NUM_WARPS; w++) begin
        count_q[w]  <= count_d[w];
        rd_ptr_q[w] <= rd_ptr_d[w];
        wr_ptr_q[w] <= wr_ptr_d[w];
      end
    end
  end

  // Instruction storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[in_idx][wr_ptr_q[in_idx]] <= in_inst;
    end
  end

  // Empty flags come straight from the registered counts.
  always_comb begin
    warp_empty = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      warp_empty[w] = (count_q[w] == '0);
    end
  end

endmodule

// File: tb/tb_gelato_inst_buffer.sv
module tb_gelato_inst_buffer;

  localparam int NW    = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } inst_t;
  typedef logic [2:0] warp_num_t;

  typedef struct {
    int    warp;
    inst_t inst;
  } ment_t;

  typedef struct {
    logic      iv;
    warp_num_t iw;
    inst_t     ii;
    logic [3:0] el;
    logic      ordy;
    logic      fv;
    warp_num_t fw;
    logic      e_rdy;
    logic      e_ov;
    warp_num_t e_ow;
    inst_t     e_oi;
    logic [3:0] e_emp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  warp_num_t  in_warp;
  inst_t      in_inst;
  logic       in_ready;
  logic [3:0] elig;
  logic       out_valid;
  warp_num_t  out_warp;
  inst_t      out_inst;
  logic       out_ready;
  logic       flush_valid;
  warp_num_t  flush_warp;
  logic [3:0] warp_empty;

  int checks;
  int failures;

  // Reference model: one ordered list of all buffered instructions.
  ment_t mq[$];
  int    m_rr;
  int    seen_warp;
  logic  seen_valid;

  gelato_inst_buffer #(
    .NUM_WARPS (NW),
    .DEPTH     (DEPTH),
    .inst_t    (inst_t),
    .warp_num_t(warp_num_t)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_warp       (in_warp),
    .in_inst       (in_inst),
    .in_ready      (in_ready),
    .issue_eligible(elig),
    .out_valid     (out_valid),
    .out_warp      (out_warp),
    .out_inst      (out_inst),
    .out_ready     (out_ready),
    .flush_valid   (flush_valid),
    .flush_warp    (flush_warp),
    .warp_empty    (warp_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic inst_t mk(input logic [6:0] op, input logic [4:0] rd);
    inst_t r;
    r.opcode = op;
    r.rd     = rd;
    r.rs1    = 5'd1;
    r.rs2    = 5'd2;
    r.imm    = 12'h0A5;
    return r;
  endfunction

  function automatic int m_count(input int w);
    int n;
    n = 0;
    foreach (mq[i]) if (mq[i].warp == w) n++;
    return n;
  endfunction

  function automatic int m_head(input int w);
    for (int i = 0; i < mq.size(); i++) if (mq[i].warp == w) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input int w, input inst_t i, input logic [3:0] e,
                     input logic ordy, input logic fv, input int fw);
    in_valid    = v;
    in_warp     = warp_num_t'(w);
    in_inst     = i;
    elig        = e;
    out_ready   = ordy;
    flush_valid = fv;
    flush_warp  = warp_num_t'(fw);
  endtask

  // One clock cycle: compare against the model, then advance the model.
  task automatic tick();
    int    sel;
    int    w;
    int    h;
    logic  e_rdy;
    logic [3:0] e_emp;
    inst_t e_oi;
    #2;
    sel = -1;
    for (int k = 1; k <= NW; k++) begin
      w = (m_rr + k) % NW;
      if (sel < 0 && m_count(w) > 0 && elig[w] && !(flush_valid && int'(flush_warp) == w))
        sel = w;
    end
    e_rdy = (int'(in_warp) < NW) && (m_count(int'(in_warp)) < DEPTH)
            && !(flush_valid && flush_warp == in_warp);
    e_oi = '0;
    if (sel >= 0) e_oi = mq[m_head(sel)].inst;
    for (int k = 0; k < NW; k++) e_emp[k] = (m_count(k) == 0);
    chk("in_ready",   64'(in_ready),   64'(e_rdy));
    chk("out_valid",  64'(out_valid),  64'(sel >= 0));
    chk("out_warp",   64'(out_warp),   64'(sel >= 0 ? sel : 0));
    chk("out_inst",   64'(out_inst),   64'(e_oi));
    chk("warp_empty", 64'(warp_empty), 64'(e_emp));
    seen_valid = out_valid;
    seen_warp  = int'(out_warp);
    @(posedge clk);
    if (sel >= 0 && out_ready) begin
      h = m_head(sel);
      mq.delete(h);
      m_rr = sel;
    end
    if (in_valid && e_rdy) mq.push_back('{warp: int'(in_warp), inst: in_inst});
    if (flush_valid)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].warp == int'(flush_warp)) mq.delete(i);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv(1'b0, 0, '0, 4'hF, 1'b0, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_rr = NW - 1;
  endtask

  initial begin
    vec_t  tv [11];
    inst_t i1, i2, i3, i4, i5;
    checks   = 0;
    failures = 0;
    i1 = mk(7'h33, 5'd5);
    i2 = mk(7'h13, 5'd1);
    i3 = mk(7'h13, 5'd2);
    i4 = mk(7'h03, 5'd3);
    i5 = mk(7'h63, 5'd4);
    //          iv    iw    ii  el     or    fv    fw    rdy   ov    ow    oi  emp
    tv[0]  = '{1'b1, 3'd2, i1, 4'hF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0, '0, 4'b1111};
    tv[1]  = '{1'b0, 3'd1, '0, 4'hF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, i1, 4'b1011};
    tv[2]  = '{1'b1, 3'd1, i2, 4'hF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, i1, 4'b1011};
    tv[3]  = '{1'b1, 3'd1, i3, 4'hF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, i2, 4'b1001};
    tv[4]  = '{1'b1, 3'd1, i4, 4'hF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, i2, 4'b1001};
    tv[5]  = '{1'b1, 3'd0, i5, 4'hF, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, i1, 4'b1001};
    tv[6]  = '{1'b0, 3'd0, '0, 4'hF, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd2, i1, 4'b1000};
    tv[7]  = '{1'b0, 3'd0, '0, 4'hF, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0, i5, 4'b1100};
    tv[8]  = '{1'b0, 3'd0, '0, 4'hF, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, i3, 4'b1101};
    tv[9]  = '{1'b1, 3'd5, i4, 4'hF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, '0, 4'b1111};
    tv[10] = '{1'b1, 3'd3, i4, 4'hF, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, '0, 4'b1111};

    rst = 1'b1;
    drv(1'b0, 0, '0, 4'hF, 1'b0, 1'b0, 0);
    mq.delete();
    m_rr = NW - 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table from reset.
    for (int r = 0; r < 11; r++) begin
      drv(tv[r].iv, int'(tv[r].iw), tv[r].ii, tv[r].el, tv[r].ordy, tv[r].fv, int'(tv[r].fw));
      #2;
      chk($sformatf("tv%0d_in_ready", r),   64'(in_ready),   64'(tv[r].e_rdy));
      chk($sformatf("tv%0d_out_valid", r),  64'(out_valid),  64'(tv[r].e_ov));
      chk($sformatf("tv%0d_out_warp", r),   64'(out_warp),   64'(tv[r].e_ow));
      chk($sformatf("tv%0d_out_inst", r),   64'(out_inst),   64'(tv[r].e_oi));
      chk($sformatf("tv%0d_warp_empty", r), 64'(warp_empty), 64'(tv[r].e_emp));
      tick();
    end

    // Round-robin order across all four warps, then wrap behaviour.
    do_reset();
    for (int w = 0; w < NW; w++) begin
      drv(1'b1, w, mk(7'h10, 5'(w)), 4'hF, 1'b0, 1'b0, 0);
      tick();
    end
    drv(1'b0, 0, '0, 4'hF, 1'b1, 1'b0, 0);
    for (int w = 0; w < NW; w++) begin
      tick();
      chk("rr_order", 64'(seen_warp), 64'(w));
    end
    drv(1'b1, 0, mk(7'h20, 5'd0), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b1, 3, mk(7'h20, 5'd3), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b0, 0, '0, 4'hF, 1'b1, 1'b0, 0);
    tick();
    chk("rr_wrap_first", 64'(seen_warp), 64'd0);
    tick();
    chk("rr_wrap_second", 64'(seen_warp), 64'd3);

    // Ineligible warp is skipped until its bit returns.
    drv(1'b1, 0, mk(7'h30, 5'd0), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b1, 0, mk(7'h31, 5'd0), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b1, 1, mk(7'h32, 5'd1), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b0, 0, '0, 4'b1101, 1'b1, 1'b0, 0);
    tick();
    chk("elig_skip_a", 64'(seen_warp), 64'd0);
    tick();
    chk("elig_skip_b", 64'(seen_warp), 64'd0);
    tick();
    chk("elig_none", 64'(seen_valid), 64'd0);
    drv(1'b0, 0, '0, 4'hF, 1'b1, 1'b0, 0);
    tick();
    chk("elig_restored", 64'(seen_warp), 64'd1);

    // Flush of warp 3 with a same-cycle enqueue attempt.
    drv(1'b1, 3, mk(7'h40, 5'd3), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b1, 3, mk(7'h41, 5'd3), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b1, 0, mk(7'h42, 5'd0), 4'hF, 1'b0, 1'b0, 0);
    tick();
    drv(1'b1, 3, mk(7'h43, 5'd3), 4'hF, 1'b0, 1'b1, 3);
    tick();
    chk("flush_offer", 64'(seen_warp), 64'd0);
    drv(1'b0, 0, '0, 4'hF, 1'b0, 1'b0, 0);
    tick();
    chk("flush_empty3", 64'(warp_empty[3]), 64'd1);
    drv(1'b0, 0, '0, 4'hF, 1'b1, 1'b0, 0);
    tick();
    chk("flush_w0_kept", 64'(seen_warp), 64'd0);

    // Asynchronous reset with five entries buffered.
    drv(1'b1, 0, mk(7'h50, 5'd0), 4'hF, 1'b0, 1'b0, 0); tick();
    drv(1'b1, 0, mk(7'h51, 5'd0), 4'hF, 1'b0, 1'b0, 0); tick();
    drv(1'b1, 1, mk(7'h52, 5'd1), 4'hF, 1'b0, 1'b0, 0); tick();
    drv(1'b1, 1, mk(7'h53, 5'd1), 4'hF, 1'b0, 1'b0, 0); tick();
    drv(1'b1, 2, mk(7'h54, 5'd2), 4'hF, 1'b0, 1'b0, 0); tick();
    drv(1'b0, 0, '0, 4'hF, 1'b0, 1'b0, 0);
    #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_empty", 64'(warp_empty), 64'hF);
    chk("async_rst_inready", 64'(in_ready), 64'd1);
    mq.delete();
    m_rr = NW - 1;
    @(negedge clk);
    rst = 1'b0;
    drv(1'b1, 3, mk(7'h60, 5'd3), 4'hF, 1'b0, 1'b0, 0); tick();
    drv(1'b1, 0, mk(7'h61, 5'd0), 4'hF, 1'b0, 1'b0, 0); tick();
    drv(1'b0, 0, '0, 4'hF, 1'b1, 1'b0, 0);
    tick();
    chk("post_rst_first", 64'(seen_warp), 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drv(($urandom % 4) != 0, int'($urandom_range(0, 5)),
          inst_t'(34'({$urandom, $urandom})), 4'($urandom), 1'($urandom),
          ($urandom % 8) == 0, int'($urandom_range(0, 3)));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
